// File: rtl/panel_pkg.sv
// Shared constants and types for the KA10 operator-panel host master.
// Holds the slave address map, key bit positions and the FSM state encoding.
package panel_pkg;

  localparam logic [5:0] PANEL_KEY_SET   = 6'o00;
  localparam logic [5:0] PANEL_KEY_CLR   = 6'o01;
  localparam logic [5:0] PANEL_IND_FIRST = 6'o10;
  localparam logic [5:0] PANEL_IND_LAST  = 6'o35;

  localparam int DEP_NXT   = 0;
  localparam int SING_INST = 19;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_IDLE,
    ST_RD,
    ST_WR_SET,
    ST_WR_CLR
  } host_state_e;

  // Mask with the low 'bits' positions set, as used for the release-all write.
  function automatic logic [31:0] low_ones(input int bits);
    logic [31:0] m;
    m = '0;
    for (int i = 0; i < 32; i++) begin
      if (i < bits) m[i] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/key_edge_sync.sv
// Two-flop synchronizer followed by a rising-edge detector for momentary keys.
// A level held high yields a single one-cycle pulse on 'rise'.
module key_edge_sync #(
  parameter int WIDTH = 20
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] async_in,
  output logic [WIDTH-1:0] rise
);

  logic [WIDTH-1:0] meta_q, meta_d;
  logic [WIDTH-1:0] sync_q, sync_d;
  logic [WIDTH-1:0] prev_q, prev_d;

  always_comb begin
    meta_d = async_in;
    sync_d = meta_q;
    prev_d = sync_q;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      meta_q <= '0;
      sync_q <= '0;
      prev_q <= '0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign rise = sync_q & ~prev_q;

endmodule

// File: rtl/panel_host_master.sv
// Avalon-MM master that scans the panel indicator window into a shadow file
// and turns key presses into timed set/clear write pairs on the panel slave.
module panel_host_master
  import panel_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = 1000,
  parameter logic [5:0]  SCAN_FIRST  = 6'o10,
  parameter logic [5:0]  SCAN_LAST   = 6'o35,
  parameter int unsigned KEY_BITS    = 20
) (
  input  logic                clk,
  input  logic                reset,
  output logic [5:0]          m_address,
  output logic                m_read,
  output logic                m_write,
  output logic [31:0]         m_writedata,
  input  logic [31:0]         m_readdata,
  input  logic                m_waitrequest,
  input  logic [KEY_BITS-1:0] key_in,
  input  logic [5:0]          lt_addr,
  output logic [31:0]         lt_data,
  output logic                scan_done
);

  localparam int NWORDS = int'(SCAN_LAST) - int'(SCAN_FIRST) + 1;
  localparam int CNT_W  = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [CNT_W-1:0] HOLD_RELOAD = CNT_W'(HOLD_CYCLES - 1);

  host_state_e state_q, state_d;

  logic                m_read_q, m_read_d;
  logic                m_write_q, m_write_d;
  logic [5:0]          m_address_q, m_address_d;
  logic [31:0]         m_writedata_q, m_writedata_d;

  logic [KEY_BITS-1:0] pending_q, pending_d;
  logic [KEY_BITS-1:0] held_q, held_d;
  logic [KEY_BITS-1:0] key_rise;
  logic [KEY_BITS-1:0] cap_mask;
  logic [CNT_W-1:0]    hold_cnt_q, hold_cnt_d;
  logic [5:0]          scan_ptr_q, scan_ptr_d;
  logic [31:0]         shadow_q [NWORDS];
  logic [31:0]         shadow_d [NWORDS];
  logic [31:0]         lt_data_q, lt_data_d;
  logic                scan_done_q, scan_done_d;

  logic bus_done, rd_done, set_done, clr_done;

  key_edge_sync #(.WIDTH(KEY_BITS)) u_key_sync (
    .clk      (clk),
    .reset    (reset),
    .async_in (key_in),
    .rise     (key_rise)
  );

  // The write data register doubles as the mask captured on entry to a write.
  assign cap_mask = m_writedata_q[KEY_BITS-1:0];
  assign bus_done = (m_read_q | m_write_q) & ~m_waitrequest;
  assign rd_done  = (state_q == ST_RD) & bus_done;
  assign set_done = (state_q == ST_WR_SET) & bus_done;
  assign clr_done = (state_q == ST_WR_CLR) & bus_done;

  always_ff @(posedge clk) begin
    if (!reset) state_q <= ST_INIT;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if ((held_q != '0) && (hold_cnt_q == '0)) state_d = ST_WR_CLR;
        else if (pending_q != '0)                 state_d = ST_WR_SET;
        else                                      state_d = ST_RD;
      end
      ST_INIT, ST_RD, ST_WR_SET, ST_WR_CLR: begin
        if (bus_done) state_d = ST_IDLE;
      end
      default: state_d = ST_INIT;
    endcase
  end

  // Bus outputs are registered, so they follow the state being entered.
  always_comb begin
    m_read_d      = 1'b0;
    m_write_d     = 1'b0;
    m_address_d   = m_address_q;
    m_writedata_d = m_writedata_q;
    unique case (state_d)
      ST_INIT: begin
        m_write_d     = 1'b1;
        m_address_d   = PANEL_KEY_CLR;
        m_writedata_d = low_ones(KEY_BITS);
      end
      ST_RD: begin
        m_read_d    = 1'b1;
        m_address_d = scan_ptr_q;
      end
      ST_WR_SET: begin
        m_write_d   = 1'b1;
        m_address_d = PANEL_KEY_SET;
        if (state_q != ST_WR_SET) m_writedata_d = 32'(pending_q);
      end
      ST_WR_CLR: begin
        m_write_d   = 1'b1;
        m_address_d = PANEL_KEY_CLR;
        if (state_q != ST_WR_CLR) m_writedata_d = 32'(held_q);
      end
      default: ;
    endcase
  end

  always_comb begin
    pending_d  = pending_q | key_rise;
    held_d     = held_q;
    hold_cnt_d = (hold_cnt_q != '0) ? hold_cnt_q - CNT_W'(1) : hold_cnt_q;
    if (set_done) begin
      pending_d  = (pending_q & ~cap_mask) | key_rise;
      held_d     = held_q | cap_mask;
      hold_cnt_d = HOLD_RELOAD;
    end
    if (clr_done) held_d = held_q & ~cap_mask;
  end

  always_comb begin
    scan_ptr_d  = scan_ptr_q;
    scan_done_d = 1'b0;
    shadow_d    = shadow_q;
    if (rd_done) begin
      for (int i = 0; i < NWORDS; i++) begin
        if (scan_ptr_q == SCAN_FIRST + 6'(i)) shadow_d[i] = m_readdata;
      end
      if (scan_ptr_q == SCAN_LAST) begin
        scan_ptr_d  = SCAN_FIRST;
        scan_done_d = 1'b1;
      end else begin
        scan_ptr_d = scan_ptr_q + 6'd1;
      end
    end
    // Reads shadow_q, so a same-cycle scan write is seen one cycle later.
    lt_data_d = '0;
    for (int i = 0; i < NWORDS; i++) begin
      if (lt_addr == SCAN_FIRST + 6'(i)) lt_data_d = shadow_q[i];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      m_read_q      <= 1'b0;
      m_write_q     <= 1'b0;
      m_address_q   <= '0;
      m_writedata_q <= '0;
      pending_q     <= '0;
      held_q        <= '0;
      hold_cnt_q    <= '0;
      scan_ptr_q    <= SCAN_FIRST;
      lt_data_q     <= '0;
      scan_done_q   <= 1'b0;
      for (int i = 0; i < NWORDS; i++) shadow_q[i] <= '0;
    end else begin
      m_read_q      <= m_read_d;
      m_write_q     <= m_write_d;
      m_address_q   <= m_address_d;
      m_writedata_q <= m_writedata_d;
      pending_q     <= pending_d;
      held_q        <= held_d;
      hold_cnt_q    <= hold_cnt_d;
      scan_ptr_q    <= scan_ptr_d;
      lt_data_q     <= lt_data_d;
      scan_done_q   <= scan_done_d;
      for (int i = 0; i < NWORDS; i++) shadow_q[i] <= shadow_d[i];
    end
  end

  assign m_read      = m_read_q;
  assign m_write     = m_write_q;
  assign m_address   = m_address_q;
  assign m_writedata = m_writedata_q;
  assign lt_data     = lt_data_q;
  assign scan_done   = scan_done_q;

endmodule

// File: tb/tb_panel_host_master.sv
// Randomized bench for panel_host_master against a transaction-level model
// of the scan order, shadow contents and key press/hold/release rules.
module tb_panel_host_master;

  localparam int HOLD  = 4;
  localparam int KB    = 20;
  localparam int FIRST = 8;
  localparam int LAST  = 29;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [5:0]    m_address;
  logic          m_read, m_write;
  logic [31:0]   m_writedata;
  logic [31:0]   m_readdata = '0;
  logic          m_waitrequest = 1'b0;
  logic [KB-1:0] key_in = '0;
  logic [5:0]    lt_addr = '0;
  logic [31:0]   lt_data;
  logic          scan_done;

  panel_host_master #(
    .HOLD_CYCLES (HOLD),
    .SCAN_FIRST  (6'o10),
    .SCAN_LAST   (6'o35),
    .KEY_BITS    (KB)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .m_address     (m_address),
    .m_read        (m_read),
    .m_write       (m_write),
    .m_writedata   (m_writedata),
    .m_readdata    (m_readdata),
    .m_waitrequest (m_waitrequest),
    .key_in        (key_in),
    .lt_addr       (lt_addr),
    .lt_data       (lt_data),
    .scan_done     (scan_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, want %h", tag, actual, expected);
    end
  endtask

  // Slave model: wait policy and read data, driven just after each edge.
  int wait_mode = 0;
  bit rnd_data  = 1'b0;
  int stall_cnt = 0;

  always @(posedge clk) begin
    #1;
    case (wait_mode)
      1: m_waitrequest = ($urandom_range(0, 3) == 0);
      2: m_waitrequest = 1'b1;
      3: m_waitrequest = m_write && (m_address == 6'o00);
      4: begin
        if (m_read && stall_cnt < 5) begin
          m_waitrequest = 1'b1;
          stall_cnt++;
        end else begin
          m_waitrequest = 1'b0;
        end
      end
      default: m_waitrequest = 1'b0;
    endcase
    if (wait_mode != 4) stall_cnt = 0;
    m_readdata = rnd_data ? $urandom : 32'h100 + 32'(m_address);
  end

  // Transaction-level reference model, evaluated on the falling edge.
  int            cycle = 0;
  bit            prev_rst_low = 1'b0;
  bit            prev_stall = 1'b0;
  logic          p_read, p_write;
  logic [5:0]    p_addr;
  logic [31:0]   p_data;
  logic [31:0]   exp_lt = '0;
  bit            exp_done = 1'b0;
  logic [31:0]   shadow_m [64];
  int            ptr = FIRST;
  bit            exp_init = 1'b1;
  logic [KB-1:0] model_pending = '0;
  logic [KB-1:0] model_held = '0;
  logic [KB-1:0] prev_key = '0;
  logic [KB-1:0] mon_rise;
  int            last_done = 0;
  bit            any_wait = 1'b0;
  int            last_set_cycle = 0;
  int            last_clr_cycle = 0;
  int            set_count = 0;
  int            clr_count = 0;
  int            init_count = 0;
  logic [31:0]   last_set_data = '0;
  logic [31:0]   last_clr_data = '0;

  always @(negedge clk) begin
    cycle++;
    if (prev_rst_low) begin
      checkOutput("rst_read", 32'(m_read), 32'd0);
      checkOutput("rst_write", 32'(m_write), 32'd0);
      checkOutput("rst_addr", 32'(m_address), 32'd0);
      checkOutput("rst_wdata", m_writedata, 32'd0);
      checkOutput("rst_lt", lt_data, 32'd0);
      checkOutput("rst_done", 32'(scan_done), 32'd0);
    end else begin
      checkOutput("lt_data", lt_data, exp_lt);
      checkOutput("scan_done", 32'(scan_done), 32'(exp_done));
      if (prev_stall) begin
        checkOutput("stall_read", 32'(m_read), 32'(p_read));
        checkOutput("stall_write", 32'(m_write), 32'(p_write));
        checkOutput("stall_addr", 32'(m_address), 32'(p_addr));
        checkOutput("stall_wdata", m_writedata, p_data);
      end
    end
    checkOutput("one_strobe", 32'(m_read & m_write), 32'd0);

    if (!reset) begin
      prev_rst_low  = 1'b1;
      prev_stall    = 1'b0;
      for (int i = 0; i < 64; i++) shadow_m[i] = '0;
      ptr           = FIRST;
      exp_init      = 1'b1;
      model_pending = '0;
      model_held    = '0;
      prev_key      = '0;
      last_done     = cycle;
      any_wait      = 1'b0;
      exp_lt        = '0;
      exp_done      = 1'b0;
    end else begin
      prev_rst_low = 1'b0;
      mon_rise = key_in & ~prev_key;
      prev_key = key_in;
      model_pending |= mon_rise;
      exp_lt   = (lt_addr >= FIRST && lt_addr <= LAST) ? shadow_m[lt_addr] : 32'd0;
      exp_done = 1'b0;
      prev_stall = (m_read | m_write) & m_waitrequest;
      p_read = m_read; p_write = m_write; p_addr = m_address; p_data = m_writedata;
      if (prev_stall) any_wait = 1'b1;
      if ((m_read | m_write) && !m_waitrequest) begin
        if (!any_wait) checkOutput("txn_gap", 32'(cycle - last_done), 32'd2);
        last_done = cycle;
        any_wait  = 1'b0;
        if (exp_init) begin
          checkOutput("init_write", 32'(m_write), 32'd1);
          checkOutput("init_addr", 32'(m_address), 32'(6'o01));
          checkOutput("init_data", m_writedata, 32'h000FFFFF);
          exp_init = 1'b0;
          init_count++;
        end else if (m_read) begin
          checkOutput("rd_addr", 32'(m_address), 32'(ptr));
          shadow_m[ptr] = m_readdata;
          if (ptr == LAST) begin
            exp_done = 1'b1;
            ptr = FIRST;
          end else begin
            ptr++;
          end
        end else if (m_address == 6'o00) begin
          checkOutput("set_nonzero", 32'(m_writedata != 0), 32'd1);
          checkOutput("set_subset", m_writedata & ~32'(model_pending), 32'd0);
          model_pending &= ~m_writedata[KB-1:0];
          model_held    |= m_writedata[KB-1:0];
          last_set_cycle = cycle;
          last_set_data  = m_writedata;
          set_count++;
        end else if (m_address == 6'o01) begin
          checkOutput("clr_data", m_writedata, 32'(model_held));
          checkOutput("clr_hold_time", 32'((cycle - last_set_cycle) >= HOLD + 1), 32'd1);
          model_held    &= ~m_writedata[KB-1:0];
          last_clr_cycle = cycle;
          last_clr_data  = m_writedata;
          clr_count++;
        end else begin
          checkOutput("wr_addr", 32'(m_address), 32'(6'o01));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic applyStimulus(input logic [KB-1:0] keys, input logic [5:0] addr, input int cycles);
    key_in  = keys;
    lt_addr = addr;
    repeat (cycles) tick();
  endtask

  task automatic waitSets(input int target, input string tag);
    int n;
    n = 0;
    while (set_count < target && n < 200) begin tick(); n++; end
    if (set_count < target) checkOutput(tag, 32'(set_count), 32'(target));
  endtask

  task automatic waitClrs(input int target, input string tag);
    int n;
    n = 0;
    while (clr_count < target && n < 200) begin tick(); n++; end
    if (clr_count < target) checkOutput(tag, 32'(clr_count), 32'(target));
  endtask

  task automatic waitSetStrobe(input string tag);
    int n;
    n = 0;
    while (!(m_write && m_address == 6'o00) && n < 100) begin tick(); n++; end
    if (!(m_write && m_address == 6'o00)) checkOutput(tag, 32'd0, 32'd1);
  endtask

  int s0, c0, stalled, saved_sets, saved_inits;
  int key_timer, gap, k;
  int last_press [KB];

  initial begin
    // Reset and first scan with a deterministic slave.
    reset = 1'b0;
    applyStimulus('0, 6'o00, 3);
    reset = 1'b1;
    applyStimulus('0, 6'o00, 10);
    checkOutput("init_once", 32'(init_count), 32'd1);
    applyStimulus('0, 6'o00, 50);
    applyStimulus('0, 6'o16, 2);
    checkOutput("lt_10E", lt_data, 32'h10E);
    applyStimulus('0, 6'o40, 2);
    checkOutput("lt_out_of_range", lt_data, 32'd0);

    // Single key press with a short hold.
    s0 = set_count; c0 = clr_count;
    applyStimulus(20'h00100, 6'o12, 5);
    applyStimulus('0, 6'o12, 1);
    waitSets(s0 + 1, "timeout_set8");
    checkOutput("set8_data", last_set_data, 32'h100);
    waitClrs(c0 + 1, "timeout_clr8");
    checkOutput("clr8_data", last_clr_data, 32'h100);
    checkOutput("clr8_within6", 32'((last_clr_cycle - last_set_cycle) <= 6), 32'd1);
    applyStimulus('0, 6'o12, 20);

    // Second key arrives while the first set write is stalled.
    s0 = set_count; c0 = clr_count;
    wait_mode = 3;
    applyStimulus(20'h00100, 6'o13, 1);
    waitSetStrobe("timeout_stall_set");
    applyStimulus(20'h00008, 6'o13, 6);
    wait_mode = 0;
    waitSets(s0 + 1, "timeout_set_a");
    checkOutput("set_a_data", last_set_data, 32'h100);
    waitSets(s0 + 2, "timeout_set_b");
    checkOutput("set_b_data", last_set_data, 32'h8);
    applyStimulus('0, 6'o13, 1);
    waitClrs(c0 + 1, "timeout_clr_ab");
    checkOutput("clr_ab_data", last_clr_data, 32'h108);
    applyStimulus('0, 6'o13, 20);
    checkOutput("pend_flush_c", 32'(model_pending), 32'd0);
    checkOutput("held_flush_c", 32'(model_held), 32'd0);

    // A read stalled for five cycles with changing read data.
    rnd_data = 1'b1;
    wait_mode = 4;
    stalled = 0;
    for (int i = 0; i < 30; i++) begin
      lt_addr = 6'($urandom_range(FIRST, LAST));
      tick();
      if (m_read && m_waitrequest) stalled++;
    end
    checkOutput("read_stall_cycles", 32'(stalled), 32'd5);
    wait_mode = 0;

    // Randomized keys, stalls, read data and shadow lookups.
    wait_mode = 1;
    for (int i = 0; i < KB; i++) last_press[i] = -1000;
    key_timer = 0; gap = 0;
    for (int n = 0; n < 1500; n++) begin
      lt_addr = 6'($urandom_range(0, 63));
      if (key_timer > 0) begin
        key_timer--;
        if (key_timer == 0) begin
          key_in = '0;
          gap = $urandom_range(0, 15);
        end
      end else if (gap > 0) begin
        gap--;
      end else begin
        for (int j = 0; j < 2; j++) begin
          k = $urandom_range(0, KB - 1);
          if (n - last_press[k] > 100 && (j == 0 || $urandom_range(0, 1) == 1)) begin
            key_in[k] = 1'b1;
            last_press[k] = n;
          end
        end
        if (key_in != '0) key_timer = $urandom_range(2, 8);
      end
      tick();
    end
    key_in = '0;
    wait_mode = 0;
    applyStimulus('0, 6'o20, 150);
    checkOutput("pend_flush_rand", 32'(model_pending), 32'd0);
    checkOutput("held_flush_rand", 32'(model_held), 32'd0);

    // Reset while a set write is stalled.
    rnd_data = 1'b0;
    wait_mode = 3;
    applyStimulus(20'h00020, 6'o20, 1);
    waitSetStrobe("timeout_rst_stall");
    applyStimulus('0, 6'o20, 2);
    saved_sets  = set_count;
    saved_inits = init_count;
    reset = 1'b0;
    wait_mode = 0;
    tick();
    reset = 1'b1;
    applyStimulus('0, 6'o20, 60);
    checkOutput("rst_no_press", 32'(set_count), 32'(saved_sets));
    checkOutput("rst_init_again", 32'(init_count), 32'(saved_inits + 1));
    checkOutput("held_after_rst", 32'(model_held), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
